// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin arbiter for NUM_REQ valid/ready streams
// feeding one registered valid/ready output stage.
// Optional burst mode is enabled with the STREAM_ARB_BURST_EN macro.
// In burst mode a granted requester keeps the grant for up to MAX_BURST
// consecutive beats. The default build rotates the grant after every beat.
module stream_rr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         in_valid,
    output logic [NUM_REQ-1:0]         in_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_src
);

    localparam int IDXW = $clog2(NUM_REQ);

    // Reject unsupported configurations at elaboration time.
    if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_cfg
        $error("stream_rr_arbiter: unsupported NUM_REQ/MAX_BURST");
    end

    logic [IDXW-1:0]    ptr_q, ptr_d;
    logic               outValid_q;
    logic [WIDTH-1:0]   outData_q;
    logic [IDXW-1:0]    outSrc_q;
    logic [NUM_REQ-1:0] rrGrant;
    logic [IDXW-1:0]    rrIdx;
    logic [NUM_REQ-1:0] grant;
    logic [IDXW-1:0]    grantIdx;
    logic               load;
    logic               xfer;

    // Compute the index that follows i, wrapping from the last requester to 0.
    function automatic logic [IDXW-1:0] nextIdx(input logic [IDXW-1:0] i);
        return (i == IDXW'(NUM_REQ - 1)) ? '0 : i + IDXW'(1);
    endfunction

    assign load      = !outValid_q || out_ready;
    assign in_ready  = (rst_n && load) ? grant : '0;
    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_src   = outSrc_q;

    // Find the first valid requester at or above ptr, wrapping around.
    always_comb begin
        logic            found;
        logic [IDXW-1:0] idx;
        rrGrant = '0;
        rrIdx   = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDXW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && in_valid[idx]) begin
                found        = 1'b1;
                rrGrant[idx] = 1'b1;
                rrIdx        = idx;
            end
        end
    end

`ifdef STREAM_ARB_BURST_EN
    typedef enum logic {ROTATE, HOLD} state_t;

    localparam logic [7:0] MaxBurstC = 8'(MAX_BURST);

    state_t          state_q, state_d;
    logic [IDXW-1:0] lock_q, lock_d;
    logic [7:0]      cnt_q, cnt_d;

    // Choose the grant source and sequence the burst lock and beat count.
    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        grant    = rrGrant;
        grantIdx = rrIdx;
        xfer     = load && (|rrGrant);
        case (state_q)
            ROTATE: begin
                if (xfer) begin
                    if (MAX_BURST > 1) begin
                        state_d = HOLD;
                        lock_d  = rrIdx;
                        cnt_d   = 8'd1;
                    end else begin
                        ptr_d = nextIdx(rrIdx);
                    end
                end
            end
            HOLD: begin
                grant           = '0;
                grant[lock_q]   = in_valid[lock_q];
                grantIdx        = lock_q;
                xfer            = load && in_valid[lock_q];
                if (load) begin
                    if (!in_valid[lock_q] || (cnt_q + 8'd1 == MaxBurstC)) begin
                        state_d = ROTATE;
                        ptr_d   = nextIdx(lock_q);
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ROTATE;
            end
        endcase
    end

    // Burst state, locked requester and beat count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ROTATE;
            lock_q  <= '0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    // Plain round-robin: the pointer moves past each requester that transfers.
    always_comb begin
        grant    = rrGrant;
        grantIdx = rrIdx;
        xfer     = load && (|rrGrant);
        ptr_d    = xfer ? nextIdx(rrIdx) : ptr_q;
    end
`endif

    // Pointer and output stage; the output only reloads when it is free or draining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSrc_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (load) begin
                outValid_q <= xfer;
                if (xfer) begin
                    outData_q <= in_data[grantIdx*WIDTH +: WIDTH];
                    outSrc_q  <= grantIdx;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed testbench for stream_rr_arbiter (NUM_REQ=4, WIDTH=32, MAX_BURST=4).
// Burst-mode vectors are included when STREAM_ARB_BURST_EN is defined.
module tb_stream_rr_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       inValid;
    logic [NUM_REQ-1:0]       inReady;
    logic [NUM_REQ*WIDTH-1:0] inData;
    logic                     outValid;
    logic                     outReady;
    logic [WIDTH-1:0]         outData;
    logic [1:0]               outSrc;

    int errorCount = 0;
    int checkCount = 0;

    stream_rr_arbiter #(
        .WIDTH    (WIDTH),
        .NUM_REQ  (NUM_REQ),
        .MAX_BURST(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (inValid),
        .in_ready (inReady),
        .in_data  (inData),
        .out_valid(outValid),
        .out_ready(outReady),
        .out_data (outData),
        .out_src  (outSrc)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the requester valids and the downstream ready, then let them settle.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic ready);
        inValid  = valid;
        outReady = ready;
        #1;
    endtask

    // Set one requester's payload.
    task automatic setData(input int idx, input logic [WIDTH-1:0] value);
        inData[idx*WIDTH +: WIDTH] = value;
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        inData = '0;
        for (int i = 0; i < NUM_REQ; i++) setData(i, WIDTH'(32'hA0 + i));
        applyStimulus(4'b1111, 1'b1);

        // Reset held five cycles with every requester valid.
        repeat (5) tick();
        checkOutput("rst_out_valid", 64'(outValid), 64'h0);
        checkOutput("rst_out_src",   64'(outSrc),   64'h0);
        checkOutput("rst_out_data",  64'(outData),  64'h0);
        checkOutput("rst_in_ready",  64'(inReady),  64'h0);

        // Round-robin with all requesters valid: sources 0,1,2,3,0.
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("rr_in_ready", 64'(inReady), 64'(4'b0001 << (k % 4)));
            tick();
            checkOutput("rr_out_valid", 64'(outValid), 64'h1);
            checkOutput("rr_out_src",   64'(outSrc),   64'(k % 4));
            checkOutput("rr_out_data",  64'(outData),  64'(32'hA0 + (k % 4)));
        end

        // Load 0xB2 from port 2, then stall the output for three cycles.
        setData(2, 32'hB2);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("bp_in_ready_load", 64'(inReady), 64'h4);
        tick();
        checkOutput("bp_out_src",  64'(outSrc),  64'h2);
        checkOutput("bp_out_data", 64'(outData), 64'hB2);
        applyStimulus(4'b1111, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("bp_stall_in_ready",  64'(inReady),  64'h0);
            checkOutput("bp_stall_out_valid", 64'(outValid), 64'h1);
            checkOutput("bp_stall_out_data",  64'(outData),  64'hB2);
            tick();
        end
        applyStimulus(4'b1111, 1'b1);
        checkOutput("bp_release_in_ready", 64'(inReady), 64'h8);
        tick();
        checkOutput("bp_release_out_src",  64'(outSrc),  64'h3);
        checkOutput("bp_release_out_data", 64'(outData), 64'hA3);

        // Sparse request from port 2 only, then idle: pointer lands on 3.
        setData(2, 32'hC2);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("sp_in_ready", 64'(inReady), 64'h4);
        tick();
        checkOutput("sp_out_valid", 64'(outValid), 64'h1);
        checkOutput("sp_out_src",   64'(outSrc),   64'h2);
        checkOutput("sp_out_data",  64'(outData),  64'hC2);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("sp_idle_in_ready", 64'(inReady), 64'h0);
        tick();
        checkOutput("sp_drain_out_valid", 64'(outValid), 64'h0);
        checkOutput("sp_hold_out_data",   64'(outData),  64'hC2);
        checkOutput("sp_hold_out_src",    64'(outSrc),   64'h2);
        applyStimulus(4'b1111, 1'b1);
        checkOutput("sp_ptr_in_ready", 64'(inReady), 64'h8);
        tick();
        checkOutput("sp_wrap_out_src", 64'(outSrc), 64'h3);

        // Reset while a beat is held: beat is discarded and pointer returns to 0.
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", 64'(inReady), 64'h0);
        tick();
        checkOutput("mid_rst_out_valid", 64'(outValid), 64'h0);
        checkOutput("mid_rst_out_src",   64'(outSrc),   64'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", 64'(inReady), 64'h1);

`ifdef STREAM_ARB_BURST_EN
        begin
            int expSrc [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
            // Bursts of four beats per requester with everyone valid.
            for (int k = 0; k < 9; k++) begin
                tick();
                checkOutput("burst_out_src", 64'(outSrc), 64'(expSrc[k]));
            end
            tick();
            checkOutput("burst_p2_second", 64'(outSrc), 64'h2);

            // Reset in the middle of a burst.
            rst_n = 1'b0;
            tick();
            checkOutput("burst_rst_out_valid", 64'(outValid), 64'h0);
            rst_n = 1'b1;
            #1;
            checkOutput("burst_rst_in_ready", 64'(inReady), 64'h1);
            tick();
            checkOutput("burst_post_rst_src0", 64'(outSrc), 64'h0);
            tick();
            checkOutput("burst_post_rst_src1", 64'(outSrc), 64'h0);

            // Locked requester drops valid: the burst ends and port 1 is next.
            applyStimulus(4'b1110, 1'b1);
            checkOutput("burst_drop_in_ready", 64'(inReady), 64'h0);
            tick();
            checkOutput("burst_drop_out_valid", 64'(outValid), 64'h0);
            checkOutput("burst_next_in_ready",  64'(inReady),  64'h2);
            tick();
            checkOutput("burst_next_out_src", 64'(outSrc), 64'h1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 Parameter WIDTH, 32, payload bits per stream.
REQ-002 Parameter NUM_REQ, 4, number of requesting streams (2..16).
REQ-003 Parameter MAX_BURST, 4, max consecutive beats per grant when burst mode compiled in (1..255).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 in_valid  input  NUM_REQ  per-requester valid; bit i = requester i.
REQ-007 in_ready  output  NUM_REQ  per-requester ready; combinational.
REQ-008 in_data  input  NUM_REQ*WIDTH  requester i payload at [i*WIDTH +: WIDTH].
REQ-009 out_valid  output  1  registered output valid.
REQ-010 out_ready  input  1  downstream ready.
REQ-011 out_data  output  WIDTH  registered payload.
REQ-012 out_src  output  $clog2(NUM_REQ)  index of requester that supplied out_data.

Function
REQ-013 Output register load enable: load = !out_valid || out_ready.
REQ-014 Grant: one-hot, combinational, first set in_valid bit searching from pointer ptr upward with wrap NUM_REQ-1 -> 0.
REQ-015 in_ready[i] = load && grant[i]; at most one in_ready bit high per cycle; in_ready never depends on in_data.
REQ-016 Transfer on port i when in_valid[i] && in_ready[i]; next cycle out_valid=1, out_data=in_data[i], out_src=i (latency 1 cycle).
REQ-017 load high with no in_valid set: out_valid clears to 0; out_data, out_src hold.
REQ-018 load low (out_valid && !out_ready): out_valid, out_data, out_src, ptr hold; all in_ready low.
REQ-019 Full throughput: with out_ready held 1 and any in_valid set, one beat transferred every cycle.
REQ-020 Without burst mode, ptr <= (i+1) mod NUM_REQ after each transfer from port i; ptr unchanged on cycles with no transfer.
REQ-021 Fairness: a requester holding in_valid is granted within NUM_REQ transfers (NUM_REQ*MAX_BURST in burst mode).
REQ-022 Requester may drop in_valid before grant; no beat is lost or duplicated.

Reset
REQ-023 While rst_n=0 at a clk edge: out_valid=0, out_data=0, out_src=0, ptr=0, FSM=ROTATE, burst count=0.
REQ-024 Reset mid-transfer discards the held beat; in_ready all 0 during reset cycle.

Configuration
REQ-025 Macro STREAM_ARB_BURST_EN compiles in burst mode; absent, behaviour is REQ-020 only.
REQ-026 With macro: FSM states ROTATE, HOLD; transfer from i in ROTATE with MAX_BURST>1 -> HOLD, lock=i, cnt=1.
REQ-027 HOLD: grant forced to lock while in_valid[lock]; each transfer cnt+1; at cnt==MAX_BURST after transfer -> ROTATE, ptr=(lock+1) mod NUM_REQ.
REQ-028 HOLD with load=1 and in_valid[lock]=0: -> ROTATE, ptr=(lock+1) mod NUM_REQ, grant that cycle from ROTATE rules using new ptr not required (no transfer that cycle).
REQ-029 HOLD with load=0: state, cnt held regardless of in_valid.

Verification
REQ-030 Reset: rst_n=0 five cycles, all in_valid=1 -> out_valid=0, out_src=0, in_ready=0000.
REQ-031 Round-robin: NUM_REQ=4, in_valid=1111, data[i]=0xA0+i, out_ready=1, no macro -> out_src 0,1,2,3,0 on consecutive cycles, out_data 0xA0..0xA3.
REQ-032 Backpressure: out_valid=1 data 0xB2, out_ready=0 three cycles -> out_data stable 0xB2, in_ready=0000; out_ready=1 -> next beat accepted same cycle.
REQ-033 Sparse: in_valid=0100 one cycle then 0000 -> one beat src=2, ptr=3, out_valid drops after consumed.
REQ-034 Burst (macro, MAX_BURST=4): in_valid=1111 -> out_src 0,0,0,0,1,1,1,1,2...; in_valid[0] drops after 2 beats -> next src=1.
REQ-035 Reset mid-HOLD: rst_n=0 at cnt=2 -> FSM=ROTATE, ptr=0, out_valid=0; first post-reset grant to port 0.
